// File: rtl/audio_sample_serializer.sv
// audio_sample_serializer: sink end of the audio path. It buffers parallel samples
// in a small FIFO and shifts them out as an I2S-style stream (sck/ws/sd).
// Ports:
//   c, rn        system clock, asynchronous active-low reset
//   x, x_valid   sample push (two's complement); x_ready is registered "not full"
//   sck, ws, sd  serial bit clock, word select (0=L, 1=R), serial data MSB first
//   underrun     one-cycle pulse when a slot starts with the FIFO empty
//   level        FIFO occupancy
module audio_sample_serializer #(
    parameter int WIDTH = 32,
    parameter int DIV   = 4,
    parameter int DEPTH = 4
) (
    input  logic                   c,
    input  logic                   rn,
    input  logic [WIDTH-1:0]       x,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic                   sck,
    output logic                   ws,
    output logic                   sd,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(WIDTH - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [CW-1:0]    div_q, div_d;
    logic             sck_q, sck_d;
    logic             ws_q, ws_d;
    logic             ur_q, ur_d;
    logic [BW-1:0]    b_q, b_d;
    logic [WIDTH-1:0] sh_q, sh_d;

    logic tick;
    logic fall;
    logic slot_start;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        tick       = (div_q == CNT_LAST);
        fall       = tick && sck_q;
        empty      = (cnt_q == '0);
        push       = x_valid && ready_q;
        slot_start = 1'b0;

        div_d = tick ? '0 : div_q + 1'b1;
        sck_d = tick ? ~sck_q : sck_q;
        b_d   = b_q;
        ws_d  = ws_q;
        sh_d  = sh_q;
        ur_d  = 1'b0;

        if (fall) begin
            b_d        = (b_q == B_LAST) ? '0 : b_q + 1'b1;
            slot_start = (b_q == B_LAST);
            if (slot_start) begin
                // the pop sees the FIFO as of this cycle: no push bypass
                sh_d = empty ? '0 : mem_q[rd_ptr_q];
                ur_d = empty;
            end else begin
                sh_d = {sh_q[WIDTH-2:0], 1'b0};
            end
            // word select leads the slot by one bit
            if (b_d == B_LAST) begin
                ws_d = ~ws_q;
            end
        end

        pop = slot_start && !empty;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        ready_d = (cnt_d != FULL_LVL);
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            div_q    <= '0;
            sck_q    <= 1'b0;
            ws_q     <= 1'b0;
            ur_q     <= 1'b0;
            b_q      <= B_LAST;
            sh_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            div_q    <= div_d;
            sck_q    <= sck_d;
            ws_q     <= ws_d;
            ur_q     <= ur_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
        end
    end

    // sample storage needs no reset: occupancy is tracked by the pointers
    always_ff @(posedge c) begin
        if (push) begin
            mem_q[wr_ptr_q] <= x;
        end
    end

    assign x_ready  = ready_q;
    assign sck      = sck_q;
    assign ws       = ws_q;
    assign sd       = sh_q[WIDTH-1];
    assign underrun = ur_q;
    assign level    = cnt_q;

endmodule

// File: tb/tb_audio_sample_serializer.sv
// tb_audio_sample_serializer: directed and loopback bench for the I2S sink.
// An I2S receiver model rebuilds slots from sck rising edges.
module tb_audio_sample_serializer;

    localparam int W  = 32;
    localparam int DV = 2;
    localparam int DP = 4;

    logic         c = 1'b0;
    logic         rn = 1'b0;
    logic [W-1:0] x = '0;
    logic         x_valid = 1'b0;
    logic         x_ready;
    logic         sck;
    logic         ws;
    logic         sd;
    logic         underrun;
    logic [2:0]   level;

    int n_chk = 0;
    int n_fail = 0;

    audio_sample_serializer #(
        .WIDTH(W),
        .DIV  (DV),
        .DEPTH(DP)
    ) dut (
        .c       (c),
        .rn      (rn),
        .x       (x),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .sck     (sck),
        .ws      (ws),
        .sd      (sd),
        .underrun(underrun),
        .level   (level)
    );

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // receiver model state
    logic [W-1:0] rx_w[$];
    bit           rx_ws0[$];
    bit           rx_ws31[$];
    bit           rx_ok[$];
    bit           rx_ur[$];
    int           urun_cnt;
    int           nz_cnt;
    int           bitn;
    bit           skip;
    bit           ur_pend;
    bit           ws0_r;
    bit           ok_r;
    bit           ur_r;
    logic         sck_p;
    logic [W-1:0] wacc;

    always @(negedge c) begin
        if (!rn) begin
            sck_p    = 1'b0;
            skip     = 1'b1;
            bitn     = 0;
            ur_pend  = 1'b0;
            urun_cnt = 0;
            nz_cnt   = 0;
            wacc     = '0;
            rx_w.delete();
            rx_ws0.delete();
            rx_ws31.delete();
            rx_ok.delete();
            rx_ur.delete();
        end else begin
            if (underrun) begin
                urun_cnt++;
                ur_pend = 1'b1;
            end
            if (sck && !sck_p) begin
                if (skip) begin
                    skip = 1'b0;
                end else begin
                    if (bitn == 0) begin
                        ws0_r   = ws;
                        ok_r    = 1'b1;
                        ur_r    = ur_pend;
                        ur_pend = 1'b0;
                    end else if (bitn < W - 1 && ws != ws0_r) begin
                        ok_r = 1'b0;
                    end
                    wacc = {wacc[W-2:0], sd};
                    if (bitn == W - 1) begin
                        rx_w.push_back(wacc);
                        rx_ws0.push_back(ws0_r);
                        rx_ws31.push_back(ws);
                        rx_ok.push_back(ok_r);
                        rx_ur.push_back(ur_r);
                        if (wacc != '0) nz_cnt++;
                        bitn = 0;
                    end else begin
                        bitn++;
                    end
                end
            end
            sck_p = sck;
        end
    end

    task automatic tick1();
        @(posedge c);
        #1;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t = 0;
        while (rx_w.size() < n && t < 3000) begin
            tick1();
            t++;
        end
        chk(tag, 64'(rx_w.size() >= n), 64'(1));
    endtask

    task automatic wait_ur(input int n, input string tag);
        int t = 0;
        while (urun_cnt < n && t < 3000) begin
            tick1();
            t++;
        end
        chk(tag, 64'(urun_cnt >= n), 64'(1));
    endtask

    task automatic do_reset();
        rn      = 1'b0;
        x_valid = 1'b0;
        repeat (3) tick1();
        rn = 1'b1;
    endtask

    logic [W-1:0] bp[6];
    logic [W-1:0] sent[$];

    initial begin
        int rise_at;
        int fall_at;
        int idx;
        int t;
        int j;
        int errs;
        int uerr;
        int n_empty;
        bit rdy;
        bit full_chk;
        bit pop_seen;

        bp[0] = 32'h12345678;
        bp[1] = 32'h80000001;
        bp[2] = 32'hFFFFFFFF;
        bp[3] = 32'h0F0F0F0F;
        bp[4] = 32'hC3C3C3C3;
        bp[5] = 32'h00000002;

        // reset values and first sck edges, with two samples pushed
        rn = 1'b0;
        repeat (3) tick1();
        chk("rst_sck", 64'(sck), 64'(0));
        chk("rst_ws", 64'(ws), 64'(0));
        chk("rst_sd", 64'(sd), 64'(0));
        chk("rst_ur", 64'(underrun), 64'(0));
        chk("rst_lvl", 64'(level), 64'(0));
        chk("rst_rdy", 64'(x_ready), 64'(1));

        x       = 32'hA5000001;
        x_valid = 1'b1;
        rn      = 1'b1;
        rise_at = 0;
        fall_at = 0;
        for (int k = 1; k <= 6; k++) begin
            tick1();
            if (k == 1) x = 32'h80000000;
            if (k == 2) begin
                x_valid = 1'b0;
                chk("push2_lvl", 64'(level), 64'(2));
            end
            if (sck && rise_at == 0) rise_at = k;
            if (!sck && rise_at != 0 && fall_at == 0) fall_at = k;
            if (k == 4) begin
                chk("pop_msb", 64'(sd), 64'(1));
                chk("pop_lvl", 64'(level), 64'(1));
            end
        end
        chk("first_rise", 64'(rise_at), 64'(DV));
        chk("first_fall", 64'(fall_at), 64'(2 * DV));

        // basic frame
        wait_rx(2, "frame_tmo");
        chk("L_data", 64'(rx_w[0]), 64'(32'hA5000001));
        chk("L_ws", 64'(rx_ws0[0]), 64'(0));
        chk("L_ws_stable", 64'(rx_ok[0]), 64'(1));
        chk("L_ws_lead", 64'(rx_ws31[0]), 64'(1));
        chk("L_ur", 64'(rx_ur[0]), 64'(0));
        chk("R_data", 64'(rx_w[1]), 64'(32'h80000000));
        chk("R_ws", 64'(rx_ws0[1]), 64'(1));
        chk("R_ws_lead", 64'(rx_ws31[1]), 64'(0));
        chk("R_ur", 64'(rx_ur[1]), 64'(0));

        // underrun frame, then a sample into the following slot
        wait_ur(2, "ur_tmo");
        x       = 32'h7FFFFFFF;
        x_valid = 1'b1;
        tick1();
        x_valid = 1'b0;
        wait_rx(5, "ur_rx_tmo");
        chk("ur_d2", 64'(rx_w[2]), 64'(0));
        chk("ur_d3", 64'(rx_w[3]), 64'(0));
        chk("ur_f2", 64'(rx_ur[2]), 64'(1));
        chk("ur_f3", 64'(rx_ur[3]), 64'(1));
        chk("ur_cnt", 64'(urun_cnt), 64'(2));
        chk("ur_next", 64'(rx_w[4]), 64'(32'h7FFFFFFF));
        chk("ur_next_ws", 64'(rx_ws0[4]), 64'(0));
        chk("ur_next_f", 64'(rx_ur[4]), 64'(0));

        // backpressure
        do_reset();
        wait_ur(1, "bp_ur_tmo");
        idx      = 0;
        t        = 0;
        full_chk = 1'b0;
        pop_seen = 1'b0;
        x        = bp[0];
        x_valid  = 1'b1;
        while (idx < 6 && t < 600) begin
            rdy = x_ready;
            tick1();
            t++;
            if (rdy) begin
                idx++;
                if (idx < 6) x = bp[idx];
                else x_valid = 1'b0;
                if (idx == 5) chk("bp_refill", 64'(level), 64'(4));
            end
            if (idx == 4 && !full_chk) begin
                full_chk = 1'b1;
                chk("bp_lvl4", 64'(level), 64'(4));
                chk("bp_rdy0", 64'(x_ready), 64'(0));
            end
            if (full_chk && !pop_seen && level == 3) begin
                pop_seen = 1'b1;
                chk("bp_rdy_back", 64'(x_ready), 64'(1));
                chk("bp_held", 64'(idx), 64'(4));
            end
        end
        x_valid = 1'b0;
        chk("bp_all_in", 64'(idx), 64'(6));
        wait_rx(7, "bp_rx_tmo");
        chk("bp_s0", 64'(rx_ur[0]), 64'(1));
        for (int k = 1; k <= 6; k++) begin
            chk("bp_data", 64'(rx_w[k]), 64'(bp[k-1]));
            chk("bp_ws", 64'(rx_ws0[k]), 64'(k % 2));
        end

        // reset in the middle of a word
        do_reset();
        wait_ur(1, "mw_ur_tmo");
        x_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            x = 32'hDEAD0000 | 32'(k + 1);
            tick1();
        end
        x_valid = 1'b0;
        t = 0;
        while (!(rx_w.size() >= 1 && bitn >= 13) && t < 1000) begin
            tick1();
            t++;
        end
        chk("mw_reach", 64'(t < 1000), 64'(1));
        chk("mw_lvl3", 64'(level), 64'(3));
        chk("mw_ws_pre", 64'(ws), 64'(1));
        rn = 1'b0;
        #1;
        chk("mw_sck", 64'(sck), 64'(0));
        chk("mw_ws", 64'(ws), 64'(0));
        chk("mw_sd", 64'(sd), 64'(0));
        chk("mw_ur", 64'(underrun), 64'(0));
        chk("mw_lvl", 64'(level), 64'(0));
        chk("mw_rdy", 64'(x_ready), 64'(1));
        repeat (2) tick1();
        rn = 1'b1;
        wait_rx(4, "mw_rx_tmo");
        chk("mw_gone", 64'(nz_cnt), 64'(0));
        chk("mw_urcnt", 64'(urun_cnt), 64'(4));

        // loopback with random gaps
        do_reset();
        sent.delete();
        idx = 0;
        t   = 0;
        while (idx < 64 && t < 40000) begin
            repeat ($urandom_range(0, 250)) begin
                tick1();
                t++;
            end
            x       = $urandom() | 32'h1;
            x_valid = 1'b1;
            do begin
                rdy = x_ready;
                tick1();
                t++;
            end while (!rdy && t < 40000);
            if (rdy) begin
                sent.push_back(x);
                idx++;
            end
            x_valid = 1'b0;
        end
        chk("lb_pushed", 64'(idx), 64'(64));
        t = 0;
        while (nz_cnt < 64 && t < 3000) begin
            tick1();
            t++;
        end
        chk("lb_rx_all", 64'(nz_cnt), 64'(64));
        j       = 0;
        errs    = 0;
        uerr    = 0;
        n_empty = 0;
        for (int i = 0; i < rx_w.size(); i++) begin
            if (rx_ws0[i] != bit'(i % 2) || !rx_ok[i]) errs++;
            if (rx_ur[i] != (rx_w[i] == '0)) uerr++;
            if (rx_w[i] == '0) begin
                n_empty++;
            end else begin
                if (j < 64) chk("lb_data", 64'(rx_w[i]), 64'(sent[j]));
                j++;
            end
        end
        chk("lb_count", 64'(j), 64'(64));
        chk("lb_ws", 64'(errs), 64'(0));
        chk("lb_ur_flag", 64'(uerr), 64'(0));
        chk("lb_ur_cnt", 64'(urun_cnt), 64'(n_empty));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/audio_sample_serializer.md
# audio_sample_serializer

Sink end of the audio sample path. Accepts parallel signed samples via a valid/ready handshake, buffers them in a small FIFO, and shifts them out as an I2S-style serial stream (bit clock, word select, serial data) toward a DAC or a serial receiver model. Samples alternate left/right in acceptance order. An empty buffer at a slot boundary sends silence and flags an underrun.

## Interface
- `WIDTH`, default 32: sample width in bits, and serial slot length in bit-clock periods.
- `DIV`, default 4: system clocks per bit-clock half-period; must be ≥1.
- `DEPTH`, default 4: FIFO depth in samples; a power of 2, ≥2.

Ports:
- `c`  in  1  system clock; all logic on posedge.
- `rn`  in  1  reset; asynchronous assert, active-low.
- `x`  in  WIDTH  sample data, two's complement.
- `x_valid`  in  1  `x` is valid this cycle.
- `x_ready`  out  1  FIFO can accept; equals "not full", registered.
- `sck`  out  1  serial bit clock.
- `ws`  out  1  word select: 0 = left slot, 1 = right slot.
- `sd`  out  1  serial data, MSB first.
- `underrun`  out  1  one-cycle pulse when a slot starts with the FIFO empty.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset (`rn`=0, takes effect immediately, any time):
  - Outputs: `sck`=0, `ws`=0, `sd`=0, `underrun`=0, `level`=0, `x_ready`=1.
  - Internal state: FIFO emptied, divider count=0, bit index b=WIDTH-1, shift register=0.
  - Reset mid-word discards the partial word and all buffered samples.
- Push: a sample is accepted on a posedge where `x_valid`=1 and `x_ready`=1.
- `x_ready` reflects occupancy from the previous cycle. A pop in the same cycle does not make room for a push while full.
- Divider:
  - Count runs 0..DIV-1.
  - When the count reaches DIV-1, `sck` toggles and the count returns to 0.
  - A "falling event" is a cycle in which `sck` toggles 1→0.
- On each falling event, b ← (b+1) mod WIDTH. Then:
  - b becomes 0 (slot start): if FIFO non-empty, pop the head into the shift register and drive `sd`=MSB. If empty, load 0, drive `sd`=0, and pulse `underrun` for one cycle.
  - b becomes 1..WIDTH-1: shift left and drive `sd` = next bit.
  - b becomes WIDTH-1: `ws` toggles, one bit before the next slot (I2S one-bit delay).
- `ws`, `sd` and `b` change only on falling events. A receiver samples on `sck` rising.
- Channel pairing: slots strictly alternate L, R, L, R. An underrun consumes its slot, and the next popped sample goes to the next slot. The sink does not realign channels.
- Simultaneous push and pop:
  - Both occur; `level` is unchanged.
  - A push and pop on an empty FIFO in the same cycle: the pop sees empty (no bypass), so the slot underruns and the pushed sample stays in the FIFO.
- Pointers wrap modulo DEPTH; `level` saturates naturally at DEPTH (full), and no overwrite occurs.

## Timing
- `sck` period = 2·DIV clocks.
- First rising edge at posedge DIV after reset release; first falling event at posedge 2·DIV.
- Slot = WIDTH `sck` periods; frame = 2·WIDTH periods.
- Latency from acceptance into an empty FIFO to MSB on `sd`: up to the next slot start, at most WIDTH·2·DIV clocks.
- `underrun` is high exactly during the cycle after the falling event that starts an empty slot.
- `level` and `x_ready` update the cycle after a push or pop.

## Test plan
- Reset check: hold `rn`=0, then release. Required: `sck`=`ws`=`sd`=0, `x_ready`=1, `level`=0; first `sck` rise at cycle DIV and first fall at cycle 2·DIV.
- Basic frame (WIDTH=32, DIV=2): push 32'hA5000001 then 32'h80000000. Required:
  - left slot with `ws`=0 serialises 1010_0101 0…0 0001 MSB-first;
  - `ws` goes high one bit before the right slot;
  - right slot serialises 1 followed by 31 zeros;
  - `underrun` never pulses during these two slots.
- Underrun: no pushes for one frame. Required: `sd`=0 throughout and `underrun` pulses exactly twice per frame. Then push 32'h7FFFFFFF; it appears in the next slot, whichever channel that is.
- Backpressure (DEPTH=4): present 6 samples back-to-back before the first slot start. Required:
  - 4 are accepted, `level`=4, `x_ready`=0;
  - `x_ready` returns to 1 the cycle after the first pop, and the 5th is accepted then;
  - output order is unchanged.
- Reset mid-word: assert `rn` at bit 13 of a slot with 3 samples buffered. Required: immediate reset values and `level`=0, and those samples never appear.
- Loopback: a bench I2S receiver model captures 64 random samples streamed with `x_valid` toggled randomly. Required: the samples reconstruct in order with L/R alternation, and `underrun` counts match the empty slots.
